// File: rtl/nios_handshake_copier_pkg.sv
// Shared types for the Nios II handshake memory copier.
// FSM state encoding and Avalon-MM constants.
package nios_handshake_copier_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        FIN
    } state_t;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

    localparam logic [3:0] BE_ALL = 4'hF;

    // Wide enough for READ_LATENCY-1 up to 7.
    localparam int LAT_W = 3;

endpackage

// File: rtl/nios_handshake_mm_copier.sv
// Avalon-MM master that copies or fills word blocks in on-chip RAM.
// One command at a time over a valid/ready handshake, done pulse at end.
module nios_handshake_mm_copier
    import nios_handshake_copier_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int LEN_W        = 11,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [31:0]       cmd_pattern,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LATENCY - 1);

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic              op_q;
    logic [LAT_W-1:0]  lat_cnt;

    logic [LEN_W-1:0]  words_next;
    logic [ADDR_W-1:0] src_next;
    logic [ADDR_W-1:0] dst_next;
    logic              last_word;

    // Next word pointers; addresses wrap naturally at 2^ADDR_W.
    always_comb begin
        words_next = words_done + LEN_W'(1);
        src_next   = src_q + WORD_STEP;
        dst_next   = dst_q + WORD_STEP;
        last_word  = (words_next == len_q);
    end

    // Command FSM; every bus and status output is registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            src_q          <= '0;
            dst_q          <= '0;
            len_q          <= '0;
            op_q           <= OP_COPY;
            lat_cnt        <= '0;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            words_done     <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= 4'h0;
            avm_writedata  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        src_q      <= cmd_src & WORD_MASK;
                        dst_q      <= cmd_dst & WORD_MASK;
                        len_q      <= cmd_len;
                        op_q       <= cmd_op;
                        words_done <= '0;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        if (cmd_len == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (cmd_op == OP_FILL) begin
                            state          <= WR;
                            avm_write      <= 1'b1;
                            avm_byteenable <= BE_ALL;
                            avm_address    <= cmd_dst & WORD_MASK;
                            avm_writedata  <= cmd_pattern;
                        end else begin
                            state          <= RD;
                            avm_read       <= 1'b1;
                            avm_byteenable <= BE_ALL;
                            avm_address    <= cmd_src & WORD_MASK;
                        end
                    end
                end
                RD: begin
                    if (!avm_waitrequest) begin
                        state          <= RD_WAIT;
                        avm_read       <= 1'b0;
                        avm_byteenable <= 4'h0;
                        lat_cnt        <= LAT_LOAD;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        state          <= WR;
                        avm_write      <= 1'b1;
                        avm_byteenable <= BE_ALL;
                        avm_address    <= dst_q;
                        avm_writedata  <= avm_readdata;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                WR: begin
                    if (!avm_waitrequest) begin
                        words_done <= words_next;
                        src_q      <= src_next;
                        dst_q      <= dst_next;
                        if (last_word) begin
                            state          <= FIN;
                            avm_write      <= 1'b0;
                            avm_byteenable <= 4'h0;
                            done           <= 1'b1;
                            busy           <= 1'b0;
                        end else if (op_q == OP_FILL) begin
                            avm_address <= dst_next;
                        end else begin
                            state       <= RD;
                            avm_write   <= 1'b0;
                            avm_read    <= 1'b1;
                            avm_address <= src_next;
                        end
                    end
                end
                FIN: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_handshake_mm_copier.sv
// Scoreboard bench for nios_handshake_mm_copier.
// Word-level reference model predicts every bus access and completion.
module tb_nios_handshake_mm_copier;

    localparam int ADDR_W = 12;
    localparam int LEN_W  = 11;
    localparam int RL     = 1;
    localparam int WORDS  = 1 << (ADDR_W - 2);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct packed {
        int words;
        int acc;
        int lat;
        bit chk;
    } done_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_op = 1'b0;
    logic [ADDR_W-1:0] cmd_src = '0;
    logic [ADDR_W-1:0] cmd_dst = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [31:0]       cmd_pattern = '0;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  words_done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest = 1'b0;

    nios_handshake_mm_copier #(
        .ADDR_W(ADDR_W),
        .LEN_W(LEN_W),
        .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_src(cmd_src),
        .cmd_dst(cmd_dst),
        .cmd_len(cmd_len),
        .cmd_pattern(cmd_pattern),
        .busy(busy),
        .done(done),
        .words_done(words_done),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_write(avm_write),
        .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done = 0;
    int done_mark = 0;
    bit stall_en = 1'b0;
    int stall_run = 0;

    wr_t               exp_wr[$];
    logic [ADDR_W-1:0] exp_rd[$];
    done_t             exp_done[$];

    logic [31:0] mem [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic [31:0] pipe [RL];
    bit          mem_init = 1'b0;
    bit          poke_en = 1'b0;
    int          poke_idx = 0;
    logic [31:0] poke_val = '0;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Slave RAM: fixed read latency, junk on readdata when no read was accepted.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
        end else if (poke_en) begin
            mem[poke_idx] <= poke_val;
        end else if (avm_write && !avm_waitrequest) begin
            mem[avm_address[ADDR_W-1:2]] <= avm_writedata;
        end
        if (avm_read && !avm_waitrequest)
            pipe[0] <= mem[avm_address[ADDR_W-1:2]];
        else
            pipe[0] <= $urandom;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign avm_readdata = pipe[RL-1];

    // Random stalls of at most 3 consecutive cycles.
    always @(posedge clk) begin
        #1;
        if (stall_en && stall_run < 3 && $urandom_range(0, 2) == 0) begin
            avm_waitrequest = 1'b1;
            stall_run++;
        end else begin
            avm_waitrequest = 1'b0;
            stall_run = 0;
        end
    end

    logic              p_req = 1'b0;
    logic              p_wait = 1'b0;
    logic              p_rd = 1'b0;
    logic              p_wr = 1'b0;
    logic [ADDR_W-1:0] p_addr = '0;
    logic [31:0]       p_wd = '0;
    logic [3:0]        p_be = '0;

    // Monitor: pops expected accesses/completions as the DUT presents them.
    always @(negedge clk) begin
        wr_t               w;
        done_t             e;
        logic [ADDR_W-1:0] ra;
        logic [3:0]        be_exp;
        if (!reset_n) begin
            p_req = 1'b0;
        end else begin
            if (p_req && p_wait) begin
                checks++;
                if (avm_read !== p_rd || avm_write !== p_wr ||
                    avm_address !== p_addr || avm_writedata !== p_wd ||
                    avm_byteenable !== p_be) begin
                    errors++;
                    $display("FAIL stall_hold: got rd%b wr%b a=%h d=%h, required rd%b wr%b a=%h d=%h",
                             avm_read, avm_write, avm_address, avm_writedata,
                             p_rd, p_wr, p_addr, p_wd);
                end
            end
            checks++;
            be_exp = (avm_read || avm_write) ? 4'hF : 4'h0;
            if (avm_read && avm_write) begin
                errors++;
                $display("FAIL rw_overlap: read and write both 1, required at most one");
            end else if (avm_byteenable !== be_exp) begin
                errors++;
                $display("FAIL byteenable: got %h, required %h", avm_byteenable, be_exp);
            end
            checks++;
            if (busy && cmd_ready) begin
                errors++;
                $display("FAIL ready_while_busy: cmd_ready 1 with busy 1, required 0");
            end
            if (avm_write && !avm_waitrequest) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: a=%h d=%h, required no write",
                             avm_address, avm_writedata);
                end else begin
                    w = exp_wr.pop_front();
                    if (avm_address !== w.addr || avm_writedata !== w.data) begin
                        errors++;
                        $display("FAIL write: a=%h d=%h, required a=%h d=%h",
                                 avm_address, avm_writedata, w.addr, w.data);
                    end
                end
            end
            if (avm_read && !avm_waitrequest) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: a=%h, required no read", avm_address);
                end else begin
                    ra = exp_rd.pop_front();
                    if (avm_address !== ra) begin
                        errors++;
                        $display("FAIL read_addr: got %h, required %h", avm_address, ra);
                    end
                end
            end
            if (done) begin
                checks++;
                n_done++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done pulse, required none");
                end else begin
                    e = exp_done.pop_front();
                    if (int'(words_done) != e.words) begin
                        errors++;
                        $display("FAIL words_done: got %0d, required %0d", words_done, e.words);
                    end else if (e.chk && (cyc - e.acc) != e.lat) begin
                        errors++;
                        $display("FAIL done_latency: got %0d cycles, required %0d",
                                 cyc - e.acc, e.lat);
                    end
                end
            end
            p_req  = avm_read | avm_write;
            p_wait = avm_waitrequest;
            p_rd   = avm_read;
            p_wr   = avm_write;
            p_addr = avm_address;
            p_wd   = avm_writedata;
            p_be   = avm_byteenable;
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals();
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_words_done", 32'(words_done), 32'd0);
        check_val("rst_avm_read", 32'(avm_read), 32'd0);
        check_val("rst_avm_write", 32'(avm_write), 32'd0);
        check_val("rst_avm_address", 32'(avm_address), 32'd0);
        check_val("rst_avm_writedata", avm_writedata, 32'd0);
        check_val("rst_avm_byteenable", 32'(avm_byteenable), 32'd0);
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = v;
        @(negedge clk);
        poke_en = 1'b0;
        ref_mem[idx] = v;
    endtask

    // Reference: ascending word-by-word move, so overlap semantics fall out.
    task automatic issue(input logic op, input int src, input int dst,
                         input int len, input logic [31:0] pat);
        int          s;
        int          d;
        int          t;
        logic [31:0] v;
        wr_t         w;
        done_t       e;
        for (int i = 0; i < len; i++) begin
            s = ((src >> 2) + i) % WORDS;
            d = ((dst >> 2) + i) % WORDS;
            if (op == 1'b0) begin
                exp_rd.push_back(ADDR_W'(s * 4));
                v = ref_mem[s];
            end else begin
                v = pat;
            end
            ref_mem[d] = v;
            w.addr = ADDR_W'(d * 4);
            w.data = v;
            exp_wr.push_back(w);
        end
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: cmd_ready 0 after %0d cycles, required 1", t);
        end
        done_mark   = n_done;
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_src     = ADDR_W'(src);
        cmd_dst     = ADDR_W'(dst);
        cmd_len     = LEN_W'(len);
        cmd_pattern = pat;
        e.words = len;
        e.acc   = cyc;
        e.lat   = (len == 0) ? 1 : (op ? len + 1 : (2 + RL) * len + 1);
        e.chk   = !stall_en;
        exp_done.push_back(e);
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_op      = 1'($urandom);
        cmd_src     = ADDR_W'($urandom);
        cmd_dst     = ADDR_W'($urandom);
        cmd_len     = LEN_W'($urandom);
        cmd_pattern = $urandom;
        #1;
    endtask

    task automatic wait_done(input int dst, input int len);
        int t;
        int d;
        t = 0;
        while (n_done == done_mark && t < 12 * len + 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (n_done == done_mark) begin
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles, required one", t);
        end
        check_val("writes_drained", 32'(exp_wr.size()), 32'd0);
        check_val("reads_drained", 32'(exp_rd.size()), 32'd0);
        @(negedge clk);
        #1;
        check_val("ready_after_fin", 32'(cmd_ready), 32'd1);
        check_val("busy_after_fin", 32'(busy), 32'd0);
        for (int i = 0; i < len; i++) begin
            d = ((dst >> 2) + i) % WORDS;
            check_val("readback", mem[d], ref_mem[d]);
        end
    endtask

    task automatic run_cmd(input logic op, input int src, input int dst,
                           input int len, input logic [31:0] pat);
        issue(op, src, dst, len, pat);
        wait_done(dst, len);
    endtask

    task automatic abort_test();
        int          t;
        int          nw;
        logic [31:0] orig;
        logic [31:0] w0;
        logic [31:0] w1;
        stall_en = 1'b0;
        orig = ref_mem[(12'h300 >> 2) + 2];
        w0   = ref_mem[12'h200 >> 2];
        w1   = ref_mem[(12'h200 >> 2) + 1];
        issue(1'b0, 12'h200, 12'h300, 16, 32'h0);
        t  = 0;
        nw = 0;
        while (nw < 3 && t < 200) begin
            @(negedge clk);
            #1;
            if (avm_write) nw++;
            t++;
        end
        check_val("abort_reached_wr", 32'(nw), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        exp_wr.delete();
        exp_rd.delete();
        exp_done.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("abort_no_bus", 32'({avm_read, avm_write}), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check_val("abort_ready", 32'(cmd_ready), 32'd1);
        check_val("abort_word0", mem[12'h300 >> 2], w0);
        check_val("abort_word1", mem[(12'h300 >> 2) + 1], w1);
        check_val("abort_word2_untouched", mem[(12'h300 >> 2) + 2], orig);
        for (int i = 0; i < WORDS; i++) ref_mem[i] = mem[i];
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic        op;
        int          src;
        int          dst;
        int          len;
        logic [31:0] pat;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        mem_init = 1'b1;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        check_reset_vals();
        reset_n = 1'b1;
        @(negedge clk);

        run_cmd(1'b1, 12'h010, 12'h010, 4, 32'hA5A5_0001);
        check_val("fill_words_done", 32'(words_done), 32'd4);

        poke(0, 32'h11);
        poke(1, 32'h22);
        poke(2, 32'h33);
        run_cmd(1'b0, 12'h000, 12'h100, 3, 32'h0);
        check_val("copy_w0", mem[12'h100 >> 2], 32'h11);
        check_val("copy_w2", mem[12'h108 >> 2], 32'h33);

        run_cmd(1'b0, 12'h040, 12'h080, 0, 32'h0);
        check_val("zero_words_done", 32'(words_done), 32'd0);
        run_cmd(1'b1, 12'h040, 12'h080, 0, 32'hDEAD_BEEF);

        stall_en = 1'b1;
        run_cmd(1'b0, 12'h040, 12'h380, 8, 32'h0);
        run_cmd(1'b1, 12'h0C0, 12'h0C0, 8, 32'h5A5A_F00D);
        stall_en = 1'b0;

        run_cmd(1'b1, 12'h000, 12'hFFC, 2, 32'hCAFE_0002);
        check_val("wrap_top", mem[WORDS-1], 32'hCAFE_0002);
        check_val("wrap_bottom", mem[0], 32'hCAFE_0002);

        for (int i = 0; i < 4; i++) poke(i, 32'(i + 1));
        run_cmd(1'b0, 12'h000, 12'h004, 4, 32'h0);
        for (int i = 1; i < 5; i++) check_val("overlap_rep", mem[i], 32'h1);

        run_cmd(1'b0, 12'h013, 12'h202, 5, 32'h0);

        abort_test();
        run_cmd(1'b1, 12'h000, 12'h200, 6, 32'h0BAD_F00D);

        for (int k = 0; k < 24; k++) begin
            op  = 1'($urandom_range(0, 1));
            src = int'($urandom_range(0, 4095));
            dst = int'($urandom_range(0, 4095));
            len = int'($urandom_range(0, 24));
            if (k % 8 == 7) len = int'($urandom_range(25, 80));
            pat = $urandom;
            stall_en = 1'($urandom_range(0, 1));
            run_cmd(op, src, dst, len, pat);
        end
        stall_en = 1'b0;

        run_cmd(1'b1, 12'h000, 12'h000, 1024, 32'h7777_1024);
        check_val("max_words_done", 32'(words_done), 32'd1024);
        run_cmd(1'b0, 12'h000, 12'h800, 1024, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_handshake_mm_copier.md
Name: nios_handshake_mm_copier

Overview:
- Avalon-MM master (initiator) that drives the 32-bit single-port on-chip memory slave: 1024 words, fixed read latency 1, no waitrequest.
- Executes one command at a time, either a word copy or a word fill, then reports completion.
- Sits between the Nios II control logic, which issues commands over a valid/ready handshake, and the memory's s1/s2 slave port through the Qsys interconnect.

Parameters:
- ADDR_W, 12: byte-address width; bits [1:0] are always driven 0 (word aligned).
- LEN_W, 11: word-count width; 0 to 1024 words.
- READ_LATENCY, 1: cycles from an accepted read to a valid avm_readdata; legal range 1 to 4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  1  0 = copy, 1 = fill
- cmd_src  in  ADDR_W  copy source byte address; bits [1:0] ignored
- cmd_dst  in  ADDR_W  destination byte address; bits [1:0] ignored
- cmd_len  in  LEN_W  word count
- cmd_pattern  in  32  fill word
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- words_done  out  LEN_W  words written for the current or last command
- avm_address  out  ADDR_W  master byte address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_byteenable  out  4  constant 4'hF whenever read or write is asserted, else 0
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  interconnect stall; tie 0 for direct connection

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, words_done=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0.
- Reset mid-command aborts immediately. No further bus cycles are issued. The partially written destination is left as is.
- States: IDLE, RD, RD_WAIT, WR, FIN.
- IDLE:
  - cmd_ready=1.
  - On accept, latch src/dst/len/op/pattern, clear words_done, raise busy.
  - len=0: go to FIN.
  - len>0 and op=copy: go to RD.
  - len>0 and op=fill: go to WR, with writedata=pattern.
- RD:
  - avm_read=1, avm_address=src.
  - The read is accepted on the first cycle with ~avm_waitrequest; then load the latency counter with READ_LATENCY-1.
  - If READ_LATENCY=1, go to RD_WAIT for exactly one cycle.
- RD_WAIT:
  - avm_read=0.
  - Count down; when the count reaches 0, capture avm_readdata into the data register on that cycle, then go to WR.
  - Required timing: read accepted in cycle N, data sampled in cycle N+READ_LATENCY.
- WR:
  - avm_write=1, avm_address=dst, avm_writedata=data register (copy) or pattern (fill).
  - Hold all master outputs stable while avm_waitrequest=1.
  - On accept: words_done+1, src+4, dst+4.
  - If words_done+1 == len, go to FIN.
  - Otherwise go to RD (copy) or stay in WR (fill); fill therefore streams back-to-back writes, one per cycle.
- FIN: done=1 for one cycle, busy=0, go to IDLE. cmd_ready rises in the following cycle.
- A command is never accepted while busy. cmd_* is sampled only at accept, so later changes are ignored.
- Address wrap: src/dst increment modulo 2^ADDR_W; this is not an error.
- Copy throughput: 2+READ_LATENCY cycles per word with waitrequest=0. Fill throughput: 1 cycle per word.
- Overlap: copy is strictly ascending and word-by-word.
  - dst<src overlap gives a correct move.
  - dst>src overlap replicates the leading src words; this is defined and intended.
- Read and write are never asserted in the same cycle.

Decomposition:
- Shared package nios_handshake_copier_pkg:
  - state enum (IDLE, RD, RD_WAIT, WR, FIN)
  - OP_COPY/OP_FILL constants
  - BE_ALL = 4'hF
- No sub-module; the latency counter and FSM fit one module (about 200 lines).

Test Plan:
- Fill: cmd_op=1, dst=0x010, len=4, pattern=0xA5A5_0001, waitrequest=0 → writes to 0x010, 0x014, 0x018, 0x01C in 4 consecutive cycles; done pulses 1 cycle later; words_done=4; memory readback matches.
- Copy: src=0x000 preloaded with 0x11,0x22,0x33; dst=0x100; len=3; READ_LATENCY=1 → read/write alternation at 3 cycles per word; 0x100..0x108 hold 0x11,0x22,0x33; done once.
- Zero length: len=0 → no avm_read/avm_write; done 1 cycle after accept; words_done=0.
- Waitrequest: random 0–3 cycle stalls on both reads and writes during a copy of len=8 → master outputs stable during stalls; data correct; no duplicated or missing accesses.
- Wrap and overlap: fill with dst=0xFFC, len=2 → writes to 0xFFC then 0x000. Copy with src=0x000, dst=0x004, len=4 over data 0x1..0x4 → dst words all 0x1.
- Abort: assert reset_n=0 in the middle of the WR state of a len=16 copy → outputs take reset values asynchronously; after release cmd_ready=1 and a new command runs normally.
